// File: rtl/frog_pkg.sv
// Shared types and constants for the mux scan sequencer and its helpers.
//   scan_state_t : sequencer FSM states
//   MUX_WIDTH    : width of the mux data bus
//   SEL_WIDTH    : width of the mux select
package frog_pkg;

  localparam int unsigned MUX_WIDTH = 8;
  localparam int unsigned SEL_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } scan_state_t;

  // Select value a frame starts from: MSB-first walks down from the top bit.
  function automatic logic [SEL_WIDTH-1:0] first_sel(input logic msb_first);
    return msb_first ? SEL_WIDTH'(MUX_WIDTH - 1) : '0;
  endfunction

  // One select step in the direction given by the latched order flag.
  function automatic logic [SEL_WIDTH-1:0] step_sel(input logic [SEL_WIDTH-1:0] sel,
                                                    input logic                 msb_first);
    return msb_first ? (sel - SEL_WIDTH'(1)) : (sel + SEL_WIDTH'(1));
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit tick counter: counts 0..TICKS-1 while enabled and flags the last tick.
//   clk_i       : system clock
//   rst_i       : asynchronous active-high reset
//   clear_i     : force the count back to zero (wins over enable_i)
//   enable_i    : advance the count this cycle
//   last_tick_o : count is at TICKS-1
module bit_timer #(
  parameter int unsigned TICKS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic last_tick_o
);

  // TICKS=1 still needs a one-bit register; it simply never leaves zero.
  localparam int unsigned CntW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_tick_o = (cnt_q == CntW'(TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = last_tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux8_1.sv
// Plain 8:1 combinational select mux fed by the scan sequencer.
//   in_i  : eight data bits
//   sel_i : bit index to pass through
//   o_o   : selected bit
module mux8_1 (
  input  logic [7:0] in_i,
  input  logic [2:0] sel_i,
  output logic       o_o
);

  assign o_o = in_i[sel_i];

endmodule

// File: rtl/mux_scan_sequencer.sv
// Serializes an 8-bit word by stepping an external 8:1 mux through all select
// positions, holding each position for TICKS cycles, and sampling the mux
// output back into a registered serial stream.
//   clk_i            : system clock
//   rst_i            : asynchronous active-high reset
//   load_valid_i     : upstream word available
//   load_data_i      : word to serialize
//   load_msb_first_i : 1 = bit 7 first, 0 = bit 0 first (sampled with the word)
//   load_ready_o     : block can accept a word
//   mux_in_o         : registered word, drives the mux data bus
//   mux_sel_o        : registered select, drives the mux select
//   mux_o_i          : mux output returned from the mux
//   ser_out_o        : registered serial bit, idles high
//   ser_valid_o      : ser_out_o carries a frame bit
//   busy_o           : frame in flight
//   done_o           : one-cycle pulse after the final bit
module mux_scan_sequencer
  import frog_pkg::*;
#(
  parameter int unsigned TICKS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_valid_i,
  input  logic [MUX_WIDTH-1:0] load_data_i,
  input  logic                 load_msb_first_i,
  output logic                 load_ready_o,
  output logic [MUX_WIDTH-1:0] mux_in_o,
  output logic [SEL_WIDTH-1:0] mux_sel_o,
  input  logic                 mux_o_i,
  output logic                 ser_out_o,
  output logic                 ser_valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  scan_state_t          state_q, state_d;
  logic [MUX_WIDTH-1:0] word_q, word_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 msb_q, msb_d;
  logic [2:0]           bit_q, bit_d;
  logic                 ser_out_q, ser_out_d;
  logic                 ser_valid_q, ser_valid_d;

  logic in_shift;
  logic last_tick;
  logic accept;

  assign in_shift = (state_q == SHIFT);
  assign accept   = load_valid_i && (state_q == IDLE);

  // The timer is held at zero outside SHIFT so every frame starts on tick 0.
  bit_timer #(
    .TICKS(TICKS)
  ) u_bit_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (!in_shift),
    .enable_i   (in_shift),
    .last_tick_o(last_tick)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    msb_d   = msb_q;
    bit_d   = bit_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = load_data_i;
          msb_d   = load_msb_first_i;
          sel_d   = first_sel(load_msb_first_i);
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            // Final bit: leave the select parked at its end position.
            state_d = DONE;
          end else begin
            sel_d = step_sel(sel_q, msb_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The mux output reflects this cycle's select; registering it makes the
  // serial stream lag the select by exactly one cycle.
  always_comb begin
    ser_out_d   = in_shift ? mux_o_i : 1'b1;
    ser_valid_d = in_shift;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      word_q      <= '0;
      sel_q       <= '0;
      msb_q       <= 1'b0;
      bit_q       <= '0;
      ser_out_q   <= 1'b1;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      sel_q       <= sel_d;
      msb_q       <= msb_d;
      bit_q       <= bit_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  assign load_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign mux_in_o     = word_q;
  assign mux_sel_o    = sel_q;
  assign ser_out_o    = ser_out_q;
  assign ser_valid_o  = ser_valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (TICKS=4 and TICKS=1), each
// looped through its own mux8_1, checked against a frame-level model.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       lv;
  logic [7:0] ld;
  logic       lmsb;
  logic       use1;
  int         cyc;
  int         checks;
  int         failures;

  logic       rdy4, mo4, so4, sv4, bz4, dn4;
  logic [7:0] min4;
  logic [2:0] msel4;
  logic       rdy1, mo1, so1, sv1, bz1, dn1;
  logic [7:0] min1;
  logic [2:0] msel1;

  mux_scan_sequencer #(.TICKS(4)) dut4 (
    .clk_i           (clk),
    .rst_i           (rst),
    .load_valid_i    (lv && !use1),
    .load_data_i     (ld),
    .load_msb_first_i(lmsb),
    .load_ready_o    (rdy4),
    .mux_in_o        (min4),
    .mux_sel_o       (msel4),
    .mux_o_i         (mo4),
    .ser_out_o       (so4),
    .ser_valid_o     (sv4),
    .busy_o          (bz4),
    .done_o          (dn4)
  );

  mux8_1 mux4 (.in_i(min4), .sel_i(msel4), .o_o(mo4));

  mux_scan_sequencer #(.TICKS(1)) dut1 (
    .clk_i           (clk),
    .rst_i           (rst),
    .load_valid_i    (lv && use1),
    .load_data_i     (ld),
    .load_msb_first_i(lmsb),
    .load_ready_o    (rdy1),
    .mux_in_o        (min1),
    .mux_sel_o       (msel1),
    .mux_o_i         (mo1),
    .ser_out_o       (so1),
    .ser_valid_o     (sv1),
    .busy_o          (bz1),
    .done_o          (dn1)
  );

  mux8_1 mux1 (.in_i(min1), .sel_i(msel1), .o_o(mo1));

  // Observation view of whichever instance is under test.
  logic       rdy, so, sv, bz, dn;
  logic [7:0] mi;
  logic [2:0] ms;
  assign rdy = use1 ? rdy1 : rdy4;
  assign so  = use1 ? so1 : so4;
  assign sv  = use1 ? sv1 : sv4;
  assign bz  = use1 ? bz1 : bz4;
  assign dn  = use1 ? dn1 : dn4;
  assign mi  = use1 ? min1 : min4;
  assign ms  = use1 ? msel1 : msel4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit index presented at frame position p (0 = first bit out).
  function automatic int pos_idx(input logic msb, input int p);
    return msb ? 7 - p : p;
  endfunction

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_ready"}, 32'(rdy), 32'd1);
    chk({tag, "_ser_out"}, 32'(so), 32'd1);
    chk({tag, "_ser_valid"}, 32'(sv), 32'd0);
    chk({tag, "_busy"}, 32'(bz), 32'd0);
    chk({tag, "_done"}, 32'(dn), 32'd0);
    chk({tag, "_mux_sel"}, 32'(ms), 32'd0);
    chk({tag, "_mux_in"}, 32'(mi), 32'd0);
  endtask

  // Called at a negedge. Presents a word, waits for acceptance, then checks
  // every cycle of the frame up to and including the cycle ready returns.
  // hold: keep load_valid high at the end; pulse: one-cycle valid mid-frame.
  task automatic run_frame(input logic [7:0] d, input logic m, input int t,
                           input bit hold, input bit pulse, output int acc);
    int n;
    int p;
    int len;
    len  = 8 * t;
    lv   = 1'b1;
    ld   = d;
    lmsb = m;
    n    = 0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
    acc = cyc;
    @(posedge clk);
    #1;
    if (!hold) lv = 1'b0;
    for (int c = 0; c <= len + 1; c++) begin
      @(negedge clk);
      p = (c / t > 7) ? 7 : c / t;
      chk("busy", 32'(bz), (c <= len) ? 32'd1 : 32'd0);
      chk("ready", 32'(rdy), (c == len + 1) ? 32'd1 : 32'd0);
      chk("done", 32'(dn), (c == len) ? 32'd1 : 32'd0);
      chk("ser_valid", 32'(sv), (c >= 1 && c <= len) ? 32'd1 : 32'd0);
      chk("ser_out", 32'(so),
          (c >= 1 && c <= len) ? 32'(d[pos_idx(m, (c - 1) / t)]) : 32'd1);
      chk("mux_sel", 32'(ms), 32'(pos_idx(m, p)));
      chk("mux_in", 32'(mi), 32'(d));
      if (c == 2) ld = ~d;
      if (pulse && c == 5) begin
        lv = 1'b1;
        ld = 8'h5A;
      end
      if (pulse && c == 6) lv = 1'b0;
    end
  endtask

  initial begin
    int a1;
    int a2;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    lv       = 1'b0;
    ld       = 8'h00;
    lmsb     = 1'b0;
    use1     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_reset("reset4");
    use1 = 1'b1;
    #1;
    chk_idle_reset("reset1");
    use1 = 1'b0;
    @(negedge clk);

    // LSB-first, TICKS=4: A5 -> 1,0,1,0,0,1,0,1
    run_frame(8'hA5, 1'b0, 4, 1'b0, 1'b0, a1);

    // MSB-first, TICKS=1: 3C -> 0,0,1,1,1,1,0,0
    use1 = 1'b1;
    @(negedge clk);
    run_frame(8'h3C, 1'b1, 1, 1'b0, 1'b0, a1);
    use1 = 1'b0;
    @(negedge clk);

    // Back-to-back with load_valid held: period 8*TICKS+2.
    run_frame(8'hFF, 1'b0, 4, 1'b1, 1'b0, a1);
    run_frame(8'h00, 1'b0, 4, 1'b0, 1'b0, a2);
    chk("b2b_period", 32'(a2 - a1), 32'd34);

    // Load pulse while busy is ignored; no extra frame follows.
    @(negedge clk);
    run_frame(8'hC3, 1'b1, 4, 1'b0, 1'b1, a1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_extra_busy", 32'(bz), 32'd0);
      chk("no_extra_valid", 32'(sv), 32'd0);
    end

    // Reset mid-frame during bit 3 of 81.
    lv   = 1'b1;
    ld   = 8'h81;
    lmsb = 1'b0;
    @(posedge clk);
    #1;
    lv = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    chk("pre_reset_busy", 32'(bz), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle_reset("midreset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("midreset_no_done", 32'(dn), 32'd0);
      chk("midreset_no_busy", 32'(bz), 32'd0);
    end
    run_frame(8'h01, 1'b0, 4, 1'b0, 1'b0, a1);

    // Randomized frames on both instances.
    for (int k = 0; k < 6; k++) begin
      use1 = k[0];
      @(negedge clk);
      run_frame(8'($urandom), 1'($urandom), use1 ? 1 : 4, 1'b0, 1'b0, a1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
